// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of a single memory controller
module mem_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_rw,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY0   = 2'd1,
    BUSY1   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state;
  // Port that received the most recent grant; 1 after reset so port 0 wins the first tie.
  logic   last_grant;
  logic   grant0;
  logic   grant1;

  // Round-robin decision: on a tie the port not granted last time wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && (!req1_valid || last_grant)) begin
      grant0 = 1'b1;
    end else if (req1_valid) begin
      grant1 = 1'b1;
    end
  end

  // Arbitration FSM with all outputs registered; mem_ready only matters in BUSY0/BUSY1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      mem_valid  <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
      grant_cnt0 <= 16'd0;
      grant_cnt1 <= 16'd0;
      busy       <= 1'b0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0) begin
            state      <= BUSY0;
            last_grant <= 1'b0;
            mem_valid  <= 1'b1;
            mem_rw     <= req0_rw;
            mem_addr   <= req0_addr;
            mem_wdata  <= req0_wdata;
            busy       <= 1'b1;
          end else if (grant1) begin
            state      <= BUSY1;
            last_grant <= 1'b1;
            mem_valid  <= 1'b1;
            mem_rw     <= req1_rw;
            mem_addr   <= req1_addr;
            mem_wdata  <= req1_wdata;
            busy       <= 1'b1;
          end
        end
        BUSY0: begin
          if (mem_ready) begin
            state      <= RELEASE;
            mem_valid  <= 1'b0;
            req0_ready <= 1'b1;
            req0_rdata <= mem_rdata;
            if (grant_cnt0 != 16'hFFFF) begin
              grant_cnt0 <= grant_cnt0 + 16'd1;
            end
          end
        end
        BUSY1: begin
          if (mem_ready) begin
            state      <= RELEASE;
            mem_valid  <= 1'b0;
            req1_ready <= 1'b1;
            req1_rdata <= mem_rdata;
            if (grant_cnt1 != 16'hFFFF) begin
              grant_cnt1 <= grant_cnt1 + 16'd1;
            end
          end
        end
        RELEASE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          mem_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_rw, req0_ready;
  logic [19:0] req0_addr;
  logic [63:0] req0_wdata, req0_rdata;
  logic        req1_valid, req1_rw, req1_ready;
  logic [19:0] req1_addr;
  logic [63:0] req1_wdata, req1_rdata;
  logic        mem_valid, mem_rw, mem_ready;
  logic [19:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [15:0] grant_cnt0, grant_cnt1;
  logic        busy;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_W(20), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rdata(req1_rdata),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns so registered outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle memory completion pulse carrying d.
  task automatic complete(input logic [63:0] d);
    mem_ready = 1'b1;
    mem_rdata = d;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got=%0h want=0", mem_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h want=0", busy); end
    total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%0h want=0", {req0_ready, req1_ready}); end
    total++; if ({mem_rw, mem_addr, mem_wdata} !== 85'd0) begin bad++; $display("FAIL reset_mem_bus got=%0h want=0", {mem_rw, mem_addr, mem_wdata}); end
    total++; if ({req0_rdata, req1_rdata} !== 128'd0) begin bad++; $display("FAIL reset_rdata got=%0h want=0", {req0_rdata, req1_rdata}); end
    total++; if ({grant_cnt0, grant_cnt1} !== 32'd0) begin bad++; $display("FAIL reset_counters got=%0h want=0", {grant_cnt0, grant_cnt1}); end
    rst = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%0h want=0", busy); end
  endtask

  task automatic test_single_read();
    req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 20'h00010;
    tick();
    req0_valid = 1'b0;
    total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL read_mem_valid got=%0h want=1", mem_valid); end
    total++; if (mem_addr !== 20'h00010 || mem_rw !== 1'b0) begin bad++; $display("FAIL read_mem_req got=%0h/%0h want=10/0", mem_addr, mem_rw); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL read_busy got=%0h want=1", busy); end
    tick();
    tick();
    total++; if (mem_valid !== 1'b1 || req0_ready !== 1'b0) begin bad++; $display("FAIL read_wait got=%0h/%0h want=1/0", mem_valid, req0_ready); end
    complete(64'hDEADBEEF_CAFEF00D);
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL read_ready got=%0h want=1", req0_ready); end
    total++; if (req0_rdata !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("FAIL read_rdata got=%0h want=deadbeefcafef00d", req0_rdata); end
    total++; if (grant_cnt0 !== 16'd1) begin bad++; $display("FAIL read_cnt0 got=%0h want=1", grant_cnt0); end
    total++; if (mem_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL read_release got=%0h/%0h want=0/1", mem_valid, busy); end
    tick();
    total++; if (req0_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL read_idle got=%0h/%0h want=0/0", req0_ready, busy); end
    total++; if (req0_rdata !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("FAIL read_rdata_hold got=%0h want=deadbeefcafef00d", req0_rdata); end
  endtask

  task automatic test_tie();
    do_reset();
    req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 20'h00111;
    req1_valid = 1'b1; req1_rw = 1'b0; req1_addr = 20'h00222;
    tick();
    total++; if (mem_addr !== 20'h00111) begin bad++; $display("FAIL tie_first got=%0h want=111", mem_addr); end
    complete(64'hA);
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL tie_first_ready got=%0h want=2", {req0_ready, req1_ready}); end
    tick();
    tick();
    total++; if (mem_addr !== 20'h00222 || mem_valid !== 1'b1) begin bad++; $display("FAIL tie_second got=%0h/%0h want=222/1", mem_addr, mem_valid); end
    complete(64'hB);
    total++; if ({req0_ready, req1_ready} !== 2'b01 || req1_rdata !== 64'hB) begin bad++; $display("FAIL tie_second_ready got=%0h/%0h want=1/b", {req0_ready, req1_ready}, req1_rdata); end
    tick();
    tick();
    total++; if (mem_addr !== 20'h00111) begin bad++; $display("FAIL tie_third got=%0h want=111", mem_addr); end
    complete(64'hC);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    total++; if (grant_cnt0 !== 16'd2 || grant_cnt1 !== 16'd1) begin bad++; $display("FAIL tie_counts got=%0h/%0h want=2/1", grant_cnt0, grant_cnt1); end
  endtask

  task automatic test_write();
    req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = 20'hFFFFF; req1_wdata = 64'h0123456789ABCDEF;
    tick();
    req1_valid = 1'b0;
    total++; if (mem_valid !== 1'b1 || mem_rw !== 1'b1) begin bad++; $display("FAIL write_req got=%0h/%0h want=1/1", mem_valid, mem_rw); end
    total++; if (mem_addr !== 20'hFFFFF || mem_wdata !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL write_bus got=%0h/%0h want=fffff/123456789abcdef", mem_addr, mem_wdata); end
    tick();
    total++; if (req0_ready !== 1'b0 || mem_wdata !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL write_hold got=%0h/%0h want=0/123456789abcdef", req0_ready, mem_wdata); end
    complete(64'h55);
    total++; if ({req0_ready, req1_ready} !== 2'b01 || req1_rdata !== 64'h55) begin bad++; $display("FAIL write_ready got=%0h/%0h want=1/55", {req0_ready, req1_ready}, req1_rdata); end
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    total++; if ({req0_ready, req1_ready, busy} !== 3'b000 || grant_cnt1 !== 16'd2) begin bad++; $display("FAIL idle_mem_ready got=%0h/%0h want=0/2", {req0_ready, req1_ready, busy}, grant_cnt1); end
  endtask

  task automatic test_withdrawal();
    req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 20'h00AAA;
    tick();
    req0_valid = 1'b0; req0_rw = 1'b1; req0_addr = 20'h00BBB;
    tick();
    tick();
    tick();
    total++; if (mem_addr !== 20'h00AAA || mem_rw !== 1'b0 || mem_valid !== 1'b1) begin bad++; $display("FAIL withdraw_hold got=%0h/%0h/%0h want=aaa/0/1", mem_addr, mem_rw, mem_valid); end
    complete(64'h77);
    total++; if (req0_ready !== 1'b1 || req0_rdata !== 64'h77) begin bad++; $display("FAIL withdraw_ready got=%0h/%0h want=1/77", req0_ready, req0_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    req1_valid = 1'b1; req1_rw = 1'b0; req1_addr = 20'h00333;
    tick();
    req1_valid = 1'b0;
    total++; if (mem_valid !== 1'b1 || mem_addr !== 20'h00333) begin bad++; $display("FAIL midrst_grant got=%0h/%0h want=1/333", mem_valid, mem_addr); end
    do_reset();
    total++; if (busy !== 1'b0 || mem_valid !== 1'b0) begin bad++; $display("FAIL midrst_idle got=%0h/%0h want=0/0", busy, mem_valid); end
    mem_ready = 1'b1; mem_rdata = 64'h99;
    tick();
    mem_ready = 1'b0;
    total++; if ({req0_ready, req1_ready} !== 2'b00 || req1_rdata !== 64'd0) begin bad++; $display("FAIL midrst_no_ready got=%0h/%0h want=0/0", {req0_ready, req1_ready}, req1_rdata); end
    total++; if ({grant_cnt0, grant_cnt1} !== 32'd0) begin bad++; $display("FAIL midrst_counters got=%0h want=0", {grant_cnt0, grant_cnt1}); end
    req0_valid = 1'b1; req0_addr = 20'h00444; req0_rw = 1'b0;
    req1_valid = 1'b1; req1_addr = 20'h00555;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    total++; if (mem_addr !== 20'h00444) begin bad++; $display("FAIL midrst_tie got=%0h want=444", mem_addr); end
    complete(64'h1);
    tick();
  endtask

  task automatic test_saturation();
    logic [15:0] cnt1_before;
    cnt1_before = grant_cnt1;
    force dut.grant_cnt0 = 16'hFFFE;
    #1;
    release dut.grant_cnt0;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 20'h00010;
      tick();
      req0_valid = 1'b0;
      complete(64'h2);
      total++; if (req0_ready !== 1'b1 || grant_cnt0 !== 16'hFFFF) begin bad++; $display("FAIL sat_cnt0_%0d got=%0h/%0h want=1/ffff", i, req0_ready, grant_cnt0); end
      tick();
    end
    total++; if (grant_cnt1 !== cnt1_before) begin bad++; $display("FAIL sat_cnt1 got=%0h want=%0h", grant_cnt1, cnt1_before); end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_rw = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_rw = 1'b0; req1_addr = '0; req1_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    #1;
    test_reset();
    test_single_read();
    test_tie();
    test_write();
    test_withdrawal();
    test_reset_mid_op();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
